pid_velocity_controller: RTL and testbench

Parametrised incremental (velocity-form) PID controller for the temperature loop, successor to the fixed-gain, fixed-width PID stage. Each accepted `sample` strobe computes the error, forms Δu = K1·e[n] + K2·e[n-1] + K3·e[n-2] on one time-shared multiplier, adds Δu to a clamped accumulator (anti-windup), and presents a saturated actuator command with a one-cycle valid pulse. Gains are runtime inputs latched per sample. The block sits between the temperature sensor front-end and the heater PWM generator.

---
 rtl/pid_velocity_controller.sv | 169 ++++++++++++++++
 tb/tb_pid_velocity_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_velocity_controller.sv
// Incremental (velocity-form) PID controller: one time-shared multiplier forms
// delta-u over three MAC cycles, then a clamped accumulator drives a saturated command.
module pid_velocity_controller #(
    parameter int DW    = 16,
    parameter int GW    = 16,
    parameter int FRAC  = 12,
    parameter int AW    = 36,
    parameter int U_MAX = 32767,
    parameter int U_MIN = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 sample,
    input  logic signed [DW-1:0] set_temp,
    input  logic signed [DW-1:0] curr_temp,
    input  logic signed [GW-1:0] k1,
    input  logic signed [GW-1:0] k2,
    input  logic signed [GW-1:0] k3,
    output logic                 busy,
    output logic                 out_valid,
    output logic signed [DW-1:0] control_out,
    output logic                 sat_hi,
    output logic                 sat_lo,
    output logic                 overrun
);
    localparam int PW = GW + DW;
    localparam int XW = GW + DW + 2;

    // Accumulator bounds: the top bound keeps the full fractional range of U_MAX.
    localparam longint HI_L    = (longint'(U_MAX) <<< FRAC) + (longint'(1) <<< FRAC) - 64'sd1;
    localparam longint LO_L    = longint'(U_MIN) <<< FRAC;
    localparam logic signed [AW:0] ACC_HI = HI_L[AW:0];
    localparam logic signed [AW:0] ACC_LO = LO_L[AW:0];
    localparam int     CLR_INT = (U_MIN <= 0 && U_MAX >= 0) ? 0 : U_MIN;
    localparam logic signed [DW-1:0] CLR_OUT = CLR_INT[DW-1:0];

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, UPDATE} state_t;

    state_t state, state_next;

    logic signed [DW-1:0] e0, err1, err2;
    logic signed [GW-1:0] k1_r, k2_r, k3_r;
    logic signed [XW-1:0] delta;
    logic signed [AW-1:0] acc;

    logic signed [DW:0]   diff;
    logic signed [DW-1:0] e_sat;
    logic signed [GW-1:0] k_sel;
    logic signed [DW-1:0] e_sel;
    logic signed [PW-1:0] product;
    logic signed [AW:0]   sum, acc_next, acc_shift;
    logic                 clamp_hi, clamp_lo;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (sample) state_next = MAC0;
                MAC0:    state_next = MAC1;
                MAC1:    state_next = MAC2;
                MAC2:    state_next = UPDATE;
                UPDATE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Error is formed one bit wider so the subtraction cannot wrap before saturation.
    assign diff = {set_temp[DW-1], set_temp} - {curr_temp[DW-1], curr_temp};

    always_comb begin
        e_sat = diff[DW-1:0];
        if (diff[DW] != diff[DW-1])
            e_sat = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    always_comb begin
        k_sel = k1_r;
        e_sel = e0;
        case (state)
            MAC1:    begin k_sel = k2_r; e_sel = err1; end
            MAC2:    begin k_sel = k3_r; e_sel = err2; end
            default: ;
        endcase
    end

    assign product = PW'(k_sel) * PW'(e_sel);

    assign sum = (AW+1)'(acc) + (AW+1)'(delta);

    always_comb begin
        acc_next = sum;
        clamp_hi = 1'b0;
        clamp_lo = 1'b0;
        if (sum > ACC_HI) begin
            acc_next = ACC_HI;
            clamp_hi = 1'b1;
        end else if (sum < ACC_LO) begin
            acc_next = ACC_LO;
            clamp_lo = 1'b1;
        end
    end

    assign acc_shift = acc_next >>> FRAC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e0          <= '0;
            err1        <= '0;
            err2        <= '0;
            k1_r        <= '0;
            k2_r        <= '0;
            k3_r        <= '0;
            delta       <= '0;
            acc         <= '0;
            control_out <= '0;
            out_valid   <= 1'b0;
            sat_hi      <= 1'b0;
            sat_lo      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample && (state != IDLE) && !clear;
            if (clear) begin
                err1        <= '0;
                err2        <= '0;
                delta       <= '0;
                acc         <= '0;
                sat_hi      <= 1'b0;
                sat_lo      <= 1'b0;
                control_out <= CLR_OUT;
            end else begin
                case (state)
                    IDLE: begin
                        if (sample) begin
                            e0    <= e_sat;
                            k1_r  <= k1;
                            k2_r  <= k2;
                            k3_r  <= k3;
                            delta <= '0;
                        end
                    end
                    MAC0, MAC1, MAC2: delta <= delta + XW'(product);
                    UPDATE: begin
                        acc         <= acc_next[AW-1:0];
                        sat_hi      <= clamp_hi;
                        sat_lo      <= clamp_lo;
                        err2        <= err1;
                        err1        <= e0;
                        control_out <= acc_shift[DW-1:0];
                        out_valid   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_velocity_controller.sv
// Bench for pid_velocity_controller: directed vector table, multi-cycle corner
// sequences and randomized samples scored against an arithmetic reference model.
module tb_pid_velocity_controller;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clear = 1'b0;
    logic               sample = 1'b0;
    logic signed [15:0] set_temp = '0;
    logic signed [15:0] curr_temp = '0;
    logic signed [15:0] k1 = '0;
    logic signed [15:0] k2 = '0;
    logic signed [15:0] k3 = '0;
    logic               busy;
    logic               out_valid;
    logic signed [15:0] control_out;
    logic               sat_hi;
    logic               sat_lo;
    logic               overrun;

    int checks = 0;
    int failures = 0;

    logic [17:0] exp_q[$];

    localparam longint ACC_MAX = 64'sd134217727;
    localparam longint ACC_MIN = 64'sd0;

    longint m_acc = 0;
    longint m_e1 = 0;
    longint m_e2 = 0;

    typedef struct {
        bit clr;
        int st;
        int cu;
        int g1;
        int g2;
        int g3;
        int exp_out;
        bit exp_hi;
        bit exp_lo;
    } vec_t;

    vec_t vecs[8];

    pid_velocity_controller dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .sample(sample),
        .set_temp(set_temp),
        .curr_temp(curr_temp),
        .k1(k1),
        .k2(k2),
        .k3(k3),
        .busy(busy),
        .out_valid(out_valid),
        .control_out(control_out),
        .sat_hi(sat_hi),
        .sat_lo(sat_lo),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: velocity-form PID with saturated error and a clamped accumulator.
    function automatic logic [17:0] model_step(input int st, input int cu,
                                               input int g1, input int g2, input int g3);
        longint e, d, s;
        logic hi, lo;
        logic [15:0] o;
        e = longint'(st) - longint'(cu);
        if (e > 32767) e = 32767;
        if (e < -32768) e = -32768;
        d = longint'(g1) * e + longint'(g2) * m_e1 + longint'(g3) * m_e2;
        s = m_acc + d;
        hi = 1'b0;
        lo = 1'b0;
        if (s > ACC_MAX) begin
            s = ACC_MAX;
            hi = 1'b1;
        end else if (s < ACC_MIN) begin
            s = ACC_MIN;
            lo = 1'b1;
        end
        m_acc = s;
        m_e2 = m_e1;
        m_e1 = e;
        o = 16'(s >>> 12);
        return {hi, lo, o};
    endfunction

    function automatic void model_clear();
        m_acc = 0;
        m_e1 = 0;
        m_e2 = 0;
    endfunction

    // Scoreboard: every out_valid pulse must match the next expected result.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_valid actual=%0d expected=none", control_out);
            end else begin
                logic [17:0] exp_v;
                logic [17:0] got_v;
                exp_v = exp_q.pop_front();
                got_v = {sat_hi, sat_lo, control_out};
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL sb_result actual=out %0d hi %0b lo %0b expected=out %0d hi %0b lo %0b",
                             $signed(got_v[15:0]), got_v[17], got_v[16],
                             $signed(exp_v[15:0]), exp_v[17], exp_v[16]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        chk("clear_out", control_out, 0);
        chk("clear_busy", busy, 0);
        chk("clear_sat", {sat_hi, sat_lo}, 0);
    endtask

    task automatic apply_sample(input int st, input int cu, input int g1, input int g2,
                                input int g3, input bit poke);
        int lat;
        set_temp = 16'(st);
        curr_temp = 16'(cu);
        k1 = 16'(g1);
        k2 = 16'(g2);
        k3 = 16'(g3);
        exp_q.push_back(model_step(st, cu, g1, g2, g3));
        sample = 1'b1;
        tick();
        sample = 1'b0;
        chk("busy_after_accept", busy, 1);
        if (poke) begin
            k1 = 16'(g1 * 2);
            curr_temp = '0;
        end
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("valid_latency", lat, 4);
    endtask

    initial begin
        int ov_cnt;
        int vw_cnt;

        vecs[0] = '{1'b1, 100, 80, 4096, -2048, 1024, 20, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 100, 80, 4096, -2048, 1024, 30, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 100, 80, 4096, -2048, 1024, 45, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32767, -32768, 4096, 0, 0, 32767, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32767, -32768, 4096, 0, 0, 32767, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 0, 100, 4096, 0, 0, 32667, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 0, 500, 4096, 0, 0, 0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 100, 80, 4096, 0, 0, 20, 1'b0, 1'b0};

        // reset state
        tick();
        tick();
        chk("rst_out", control_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", {sat_hi, sat_lo}, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        // directed table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].clr) do_clear();
            apply_sample(vecs[i].st, vecs[i].cu, vecs[i].g1, vecs[i].g2, vecs[i].g3, 1'b0);
            chk($sformatf("vec%0d_out", i), control_out, vecs[i].exp_out);
            chk($sformatf("vec%0d_sat_hi", i), sat_hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_sat_lo", i), sat_lo, vecs[i].exp_lo);
        end

        // sample held high for 12 edges
        do_clear();
        set_temp = 16'sd100;
        curr_temp = 16'sd80;
        k1 = 16'sd4096;
        k2 = '0;
        k3 = '0;
        for (int j = 0; j < 3; j++) exp_q.push_back(model_step(100, 80, 4096, 0, 0));
        sample = 1'b1;
        ov_cnt = 0;
        vw_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("held_overrun_e%0d", i), overrun, (i % 5 != 0) ? 1 : 0);
            ov_cnt += int'(overrun);
            vw_cnt += int'(out_valid);
        end
        sample = 1'b0;
        chk("held_overrun_count", ov_cnt, 9);
        chk("held_valid_count", vw_cnt, 2);
        tick();
        tick();
        chk("held_valid_e13", out_valid, 0);
        tick();
        chk("held_valid_e14", out_valid, 1);
        chk("held_out_e14", control_out, 60);
        tick();

        // reset during MAC1
        set_temp = 16'sd100;
        curr_temp = 16'sd80;
        k1 = 16'sd4096;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_out", control_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        tick();
        apply_sample(100, 80, 4096, -2048, 1024, 1'b0);
        chk("post_reset_out", control_out, 20);
        tick();

        // clear during MAC2
        sample = 1'b1;
        tick();
        sample = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        chk("midclr_busy", busy, 0);
        chk("midclr_out", control_out, 0);
        vw_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            vw_cnt += int'(out_valid);
            tick();
        end
        chk("midclr_no_valid", vw_cnt, 0);

        // clear and sample on the same idle edge
        clear = 1'b1;
        sample = 1'b1;
        tick();
        clear = 1'b0;
        sample = 1'b0;
        chk("clrsmp_busy", busy, 0);
        chk("clrsmp_overrun", overrun, 0);
        apply_sample(100, 80, 4096, -2048, 1024, 1'b0);
        chk("post_clear_out", control_out, 20);
        tick();

        // gain and input changes while busy
        do_clear();
        apply_sample(100, 80, 4096, 0, 0, 1'b1);
        chk("gainchg_first", control_out, 20);
        apply_sample(100, 80, 8192, 0, 0, 1'b0);
        chk("gainchg_second", control_out, 60);

        // randomized samples against the model
        do_clear();
        for (int n = 0; n < 60; n++) begin
            int st, cu, g1, g2, g3, gap;
            if ($urandom_range(0, 1) == 0) begin
                st = int'($urandom_range(0, 65535)) - 32768;
                cu = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                st = int'($urandom_range(0, 2000)) - 1000;
                cu = int'($urandom_range(0, 2000)) - 1000;
            end
            g1 = int'($urandom_range(0, 16383)) - 8192;
            g2 = int'($urandom_range(0, 16383)) - 8192;
            g3 = int'($urandom_range(0, 16383)) - 8192;
            apply_sample(st, cu, g1, g2, g3, 1'b0);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
        end

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
